ipml_prefetch_fifo_v2_0_sync: RTL and testbench
===============================================

// Module: ipml_prefetch_fifo_v2_0_sync
//
// PURPOSE
// - Single-clock, parametrised first-word-fall-through FIFO: a RAM-based store plus a 2-entry
//   prefetch stage, so rd_data is valid whenever rd_vld=1 and is popped by rd_en.
// - Next generation of the prefetch FIFO. Adds occupancy count, almost flags,
//   overflow/underflow pulses and a synchronous flush.
// - Used on UART/accelerator data paths where producer and consumer share one clock.
//
// PARAMETERS
// - DATA_WIDTH       32          data bits per entry (1..1152)
// - DEPTH_WIDTH      10          RAM address width (2..16); RAM depth = 2**DEPTH_WIDTH
// - ALMOST_FULL_TH   2**DW-4     almost_full=1 when data_count >= this value
// - ALMOST_EMPTY_TH  2           almost_empty=1 when data_count <= this value
// - RAM_STYLE        "BLOCK"     "BLOCK" | "DIST": synthesis attribute on the storage array
//
// PORTS
// - clk           in   1              single clock, rising edge
// - rst_n         in   1              synchronous reset, active-low
// - flush         in   1              synchronous clear of all contents; has priority over wr_en/rd_en
// - wr_data       in   DATA_WIDTH     write data
// - wr_en         in   1              write request
// - wr_vld        out  1              space available; a write is accepted when wr_en & wr_vld
// - rd_data       out  DATA_WIDTH     head-of-FIFO data, valid while rd_vld=1
// - rd_en         in   1              pop request; a pop occurs when rd_en & rd_vld
// - rd_vld        out  1              rd_data holds a valid entry
// - data_count    out  DEPTH_WIDTH+2  total entries held: RAM + in-flight read + prefetch stage
// - almost_full   out  1              data_count >= ALMOST_FULL_TH
// - almost_empty  out  1              data_count <= ALMOST_EMPTY_TH
// - overflow      out  1              1-cycle pulse: wr_en=1 while wr_vld=0; write dropped
// - underflow     out  1              1-cycle pulse: rd_en=1 while rd_vld=0; no state change
//
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): pointers=0, RAM count=0, prefetch empty, wr_vld=1, rd_vld=0,
//   rd_data=0, data_count=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
//   RAM contents are not cleared.
// - Reset mid-operation discards all data. The first edge with rst_n=1 behaves as the empty state.
// - RAM: 1-cycle registered read. wr_ptr and rd_ptr wrap naturally at 2**DEPTH_WIDTH.
//   RAM count is tracked in a DEPTH_WIDTH+1 bit register.
// - wr_vld = (ram_count != 2**DEPTH_WIDTH). wr_vld is registered and gets no credit for a
//   same-cycle RAM read. Total capacity is therefore 2**DEPTH_WIDTH + 2.
// - RAM read issue: mem_rd = (ram_count != 0) & ((prefetch_cnt + inflight) < 2 | pop).
//   This guarantees the prefetch stage never overflows.
// - inflight: a register that is set on the cycle after mem_rd. While inflight=1, the RAM
//   output is written into the prefetch stage at the next edge.
// - Prefetch stage: 2-entry register FIFO. Its head drives rd_data. rd_vld = prefetch_cnt != 0.
//   A pop and a fill in the same cycle keep prefetch_cnt unchanged.
// - Latency: a write accepted at edge N into an empty FIFO gives rd_vld=1 after edge N+2.
//   No write-to-read bypass.
// - Throughput: back-to-back pops sustain 1 entry/clk once the prefetch stage is full.
// - data_count: +1 on accepted write, -1 on pop, unchanged when both occur. Registered.
//   almost_full and almost_empty are registered and derived from the next-state count.
// - Simultaneous wr & rd with the RAM full: the write is refused (wr_vld=0) and the pop proceeds.
//   wr_vld returns to 1 at the next edge after ram_count drops.
// - flush=1 at an edge: same result as reset, except the overflow/underflow pulses of that
//   cycle are suppressed.
// - overflow and underflow are registered pulses, asserted one cycle after the offending request.
//
// STRUCTURE
// - Package ipml_prefetch_fifo_pkg:
//   - function clog2;
//   - localparam PF_DEPTH=2;
//   - typedef of count width (DEPTH_WIDTH+2) exposed via parameterised function.
// - Sub-module ipml_prefetch_skid_v2_0: the 2-entry prefetch register FIFO.
//   - Inputs: clk, rst_n, flush, in_vld, in_data, out_rdy.
//   - Outputs: out_vld, out_data, cnt[1:0].
// - Top level holds the RAM array, pointers, read-issue logic, counters and flags.
//
// TESTING
// - Reset then idle: wr_vld=1, rd_vld=0, data_count=0, almost_empty=1, every other flag=0.
// - DW=4, write 0xA5 at edge 0 -> rd_vld=1 after edge 2, rd_data=0xA5; pop -> rd_vld=0, count=0.
// - DW=4, write 18 words with no reads -> wr_vld=0 after the 16th RAM write, data_count=18.
//   The 19th wr_en -> overflow pulse, data lost. Read all -> values in order 0..17.
// - Continuous wr_en & rd_en for 1000 cycles with random data: the output sequence matches a
//   reference model and data_count stays constant; inject rd_en with rd_vld=0 -> underflow pulse.
// - Full FIFO, flush=1 with wr_en=1 for one cycle -> next cycle data_count=0, rd_vld=0, no overflow.
// - Drive rst_n=0 for 1 cycle mid-stream with rd_vld=1 -> all outputs at reset values.
//   Refill -> first word read equals first word written after reset.

Source files
------------

// File: rtl/ipml_prefetch_fifo_pkg.sv
// Shared constants and width helpers for the prefetch FIFO family.
package ipml_prefetch_fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int PF_DEPTH = 2;
    localparam int PF_CNT_W = clog2(PF_DEPTH + 1);

    // Occupancy counter width: RAM entries plus the in-flight word plus the prefetch stage.
    function automatic int count_width(input int depth_width);
        return depth_width + 2;
    endfunction

endpackage

// File: rtl/ipml_prefetch_fifo_v2_0_sync_skid.sv
// Two-entry register FIFO that holds prefetched RAM words; its head is the FIFO output.
module ipml_prefetch_skid_v2_0
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_rdy,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [PF_CNT_W-1:0]   cnt
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [PF_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  pop;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        pop    = out_rdy & (cnt_q != '0);
        case ({in_vld, pop})
            2'b10: begin
                if (cnt_q == '0) begin
                    head_d = in_data;
                end else begin
                    tail_d = in_data;
                end
                cnt_d = cnt_q + PF_CNT_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - PF_CNT_W'(1);
            end
            2'b11: begin
                // Occupancy holds; the incoming word lands behind whatever remains.
                if (cnt_q == PF_CNT_W'(1)) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_vld  = (cnt_q != '0);
    assign out_data = head_q;
    assign cnt      = cnt_q;

endmodule

// File: rtl/ipml_prefetch_fifo_v2_0_sync.sv
// First-word-fall-through FIFO: RAM store with registered read feeding a 2-entry prefetch stage.
module ipml_prefetch_fifo_v2_0_sync
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEPTH_WIDTH     = 10,
    parameter int ALMOST_FULL_TH  = 2**DEPTH_WIDTH - 4,
    parameter int ALMOST_EMPTY_TH = 2,
    parameter     RAM_STYLE       = "BLOCK"
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_en,
    output logic                                 wr_vld,
    output logic [DATA_WIDTH-1:0]                rd_data,
    input  logic                                 rd_en,
    output logic                                 rd_vld,
    output logic [count_width(DEPTH_WIDTH)-1:0]  data_count,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int                   CW        = count_width(DEPTH_WIDTH);
    localparam int                   RAM_DEPTH = 2**DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] RAM_FULL  = (DEPTH_WIDTH+1)'(RAM_DEPTH);
    localparam logic [CW-1:0]        AF_TH     = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0]        AE_TH     = CW'(ALMOST_EMPTY_TH);

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   ram_count_q, ram_count_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   wr_vld_q, inflight_q;
    logic                   af_q, ae_q, ovf_q, unf_q;
    logic [DATA_WIDTH-1:0]  ram_rd_data_q;
    logic                   wr_acc, pop, mem_rd, pf_vld;
    logic [PF_CNT_W-1:0]    pf_cnt;
    logic [PF_CNT_W:0]      pf_load;

    always_comb begin
        wr_acc  = wr_en & wr_vld_q;
        pop     = rd_en & pf_vld;
        // Words already committed to the prefetch stage, counting the one still in the RAM pipe.
        pf_load = {1'b0, pf_cnt} + {{PF_CNT_W{1'b0}}, inflight_q};
        mem_rd  = (ram_count_q != '0) & ((pf_load < (PF_CNT_W+1)'(PF_DEPTH)) | pop);

        wr_ptr_d    = wr_ptr_q + DEPTH_WIDTH'(wr_acc);
        rd_ptr_d    = rd_ptr_q + DEPTH_WIDTH'(mem_rd);
        ram_count_d = ram_count_q + (DEPTH_WIDTH+1)'(wr_acc) - (DEPTH_WIDTH+1)'(mem_rd);
        count_d     = count_q + CW'(wr_acc) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            count_q     <= '0;
            wr_vld_q    <= 1'b1;
            inflight_q  <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            count_q     <= count_d;
            wr_vld_q    <= (ram_count_d != RAM_FULL);
            inflight_q  <= mem_rd;
            af_q        <= (count_d >= AF_TH);
            ae_q        <= (count_d <= AE_TH);
            ovf_q       <= wr_en & ~wr_vld_q;
            unf_q       <= rd_en & ~pf_vld;
        end
    end

    generate
        if (RAM_STYLE == "DIST") begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
            always_ff @(posedge clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= wr_data;
                end
                if (mem_rd) begin
                    ram_rd_data_q <= mem[rd_ptr_q];
                end
            end
        end else begin : g_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
            always_ff @(posedge clk) begin
                if (wr_acc) begin
                    mem[wr_ptr_q] <= wr_data;
                end
                if (mem_rd) begin
                    ram_rd_data_q <= mem[rd_ptr_q];
                end
            end
        end
    endgenerate

    ipml_prefetch_skid_v2_0 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (inflight_q),
        .in_data  (ram_rd_data_q),
        .out_rdy  (rd_en),
        .out_vld  (pf_vld),
        .out_data (rd_data),
        .cnt      (pf_cnt)
    );

    assign wr_vld       = wr_vld_q;
    assign rd_vld       = pf_vld;
    assign data_count   = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0_sync.sv
// Bench for the prefetch FIFO: hand-computed vector table, directed corner cases, random traffic vs queue model.
module tb_ipml_prefetch_fifo_v2_0_sync;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CW  = AW + 2;
    localparam int CAP = 2**AW + 2;
    localparam int AF  = 2**AW - 4;
    localparam int AE  = 2;

    logic          clk = 1'b0;
    logic          rst_n, flush, wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] data_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q[$];
    logic          exp_ovf, exp_unf;

    typedef struct {
        logic          we;
        logic [DW-1:0] wd;
        logic          re;
        logic          fl;
        logic          rv;
        logic [DW-1:0] rd;
        logic          wv;
        int            cnt;
        logic          ae;
        logic          af;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    ipml_prefetch_fifo_v2_0_sync #(
        .DATA_WIDTH  (DW),
        .DEPTH_WIDTH (AW),
        .RAM_STYLE   ("BLOCK")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .data_count   (data_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                         input logic fl, input logic rn);
        logic was_wv, was_rv, acc, pp;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        flush   = fl;
        rst_n   = rn;
        was_wv  = (wr_vld === 1'b1);
        was_rv  = (rd_vld === 1'b1);
        if (was_rv) begin
            if (q.size() == 0) chk("rd_vld_while_model_empty", 32'(rd_vld), 32'd0);
            else               chk("head_data", 32'(rd_data), 32'(q[0]));
        end
        acc = we & was_wv;
        pp  = re & was_rv;
        @(posedge clk);
        if (!rn || fl) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(wd);
            exp_ovf = we & ~was_wv;
            exp_unf = re & ~was_rv;
        end
        @(negedge clk);
        chk("data_count",   32'(data_count),   32'(q.size()));
        chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        chk("overflow",     32'(overflow),     32'(exp_ovf));
        chk("underflow",    32'(underflow),    32'(exp_unf));
        if (q.size() < 2**AW) chk("wr_vld_with_space", 32'(wr_vld), 32'd1);
        if (q.size() == CAP)  chk("wr_vld_at_capacity", 32'(wr_vld), 32'd0);
        if (q.size() == 0)    chk("rd_vld_when_empty", 32'(rd_vld), 32'd0);
        if (!rn || fl)        chk("rd_data_cleared", 32'(rd_data), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic we, re, fl, rn;
        int wp;

        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        exp_ovf = 1'b0; exp_unf = 1'b0;

        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("idle_wr_vld", 32'(wr_vld), 32'd1);
        chk("idle_rd_vld", 32'(rd_vld), 32'd0);
        chk("idle_count",  32'(data_count), 32'd0);
        chk("idle_ae",     32'(almost_empty), 32'd1);
        chk("idle_af",     32'(almost_full), 32'd0);

        for (int i = 0; i < 17; i++) begin
            cycle(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].fl, 1'b1);
            chk($sformatf("vec%0d_rd_vld", i), 32'(rd_vld), 32'(vecs[i].rv));
            if (vecs[i].rv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
            chk($sformatf("vec%0d_wr_vld", i), 32'(wr_vld), 32'(vecs[i].wv));
            chk($sformatf("vec%0d_count", i),  32'(data_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_ae", i),     32'(almost_empty), 32'(vecs[i].ae));
            chk($sformatf("vec%0d_af", i),     32'(almost_full), 32'(vecs[i].af));
            chk($sformatf("vec%0d_ovf", i),    32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_unf", i),    32'(underflow), 32'(vecs[i].unf));
        end

        // Fill to capacity, overflow once, then read everything back in order.
        for (int i = 0; i < CAP; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        chk("full_wr_vld", 32'(wr_vld), 32'd0);
        chk("full_count",  32'(data_count), 32'(CAP));
        chk("full_af",     32'(almost_full), 32'd1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("overflow_pulse", 32'(overflow), 32'd1);
        chk("overflow_count", 32'(data_count), 32'(CAP));
        n = 0;
        for (int k = 0; k < 60 && n < CAP; k++) begin
            if (rd_vld === 1'b1) begin
                chk($sformatf("order%0d", n), 32'(rd_data), 32'(n));
                n++;
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            if (k == 0) chk("wr_vld_after_first_pop", 32'(wr_vld), 32'd1);
        end
        chk("read_all_words", 32'(n), 32'(CAP));
        chk("read_all_count", 32'(data_count), 32'd0);

        // Flush a full FIFO with a refused write pending.
        for (int i = 0; i < CAP; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'hEF, 1'b0, 1'b1, 1'b1);
        chk("flush_no_overflow", 32'(overflow), 32'd0);
        chk("flush_count",       32'(data_count), 32'd0);
        chk("flush_rd_vld",      32'(rd_vld), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            chk("post_flush_rd_vld", 32'(rd_vld), 32'd0);
        end

        // Continuous write+read with a steady occupancy of six.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("primed_rd_vld", 32'(rd_vld), 32'd1);
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
            chk("stream_rd_vld", 32'(rd_vld), 32'd1);
            chk("stream_count",  32'(data_count), 32'd6);
        end
        for (int k = 0; k < 40 && data_count != '0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("drain_done", 32'(data_count), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("underflow_pulse", 32'(underflow), 32'd1);

        // Reset mid-stream with the output valid.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_rd_vld", 32'(rd_vld), 32'd1);
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("rst_rd_vld", 32'(rd_vld), 32'd0);
        chk("rst_wr_vld", 32'(wr_vld), 32'd1);
        chk("rst_count",  32'(data_count), 32'd0);
        chk("rst_ae",     32'(almost_empty), 32'd1);
        chk("rst_af",     32'(almost_full), 32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_unf",    32'(underflow), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("refill_rd_vld",  32'(rd_vld), 32'd1);
        chk("refill_rd_data", 32'(rd_data), 32'h3C);

        // Random traffic with occasional flush and reset, in fill-heavy, balanced and drain-heavy phases.
        for (int ph = 0; ph < 3; ph++) begin
            wp = (ph == 0) ? 80 : ((ph == 1) ? 50 : 20);
            for (int i = 0; i < 1000; i++) begin
                we = ($urandom_range(0, 99) < wp);
                re = ($urandom_range(0, 99) < (100 - wp));
                fl = ($urandom_range(0, 299) == 0);
                rn = ($urandom_range(0, 499) != 0);
                cycle(we, 8'($urandom), re, fl, rn);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
